aib_bit_sync_filt: RTL and testbench

AIB_BIT_SYNC_FILT -- requirements
Module: aib_bit_sync_filt

---
 rtl/aib_bit_sync_filt.sv | 129 ++++++++++++
 tb/tb_aib_bit_sync_filt.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/aib_bit_sync_filt.sv
// rtl/aib_bit_sync_filt.sv - multi-bit level synchroniser with per-bit glitch filter and edge pulses
//
// Purpose:
//   Brings DWIDTH independent asynchronous level signals into the clk domain
//   through a SYNC_STAGES-deep flop chain. Each bit is then qualified by a
//   consecutive-mismatch filter: data_out only follows the synchronised level
//   once it has disagreed with data_out for FILT_CNT consecutive edges.
//   FILT_CNT=0 bypasses the filter so that data_out is the last sync stage.
//   Optional registered rise/fall pulses mark each data_out change.
//
// Ports:
//   clk       - destination clock
//   rst       - asynchronous assert, active-high reset
//   data_in   - [DWIDTH] asynchronous level inputs
//   data_out  - [DWIDTH] synchronised and filtered levels
//   rise_out  - [DWIDTH] one-cycle pulse coincident with a 0->1 data_out change
//   fall_out  - [DWIDTH] one-cycle pulse coincident with a 1->0 data_out change
//
// Configuration macro:
//   AIB_BIT_SYNC_FILT_EDGE_EN - when defined, builds the rise/fall pulse flops;
//                               otherwise rise_out/fall_out are tied to 0.

module aib_bit_sync_filt #(
    parameter int                DWIDTH      = 1,
    parameter int                SYNC_STAGES = 2,
    parameter int                FILT_CNT    = 4,
    parameter logic [DWIDTH-1:0] RESET_VAL   = {DWIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic [DWIDTH-1:0] rise_out,
    output logic [DWIDTH-1:0] fall_out
);

    // Parameter legality
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("aib_bit_sync_filt: SYNC_STAGES must be in 2..4");
    end
    if (FILT_CNT < 0 || FILT_CNT > 255) begin : g_bad_filt_cnt
        $error("aib_bit_sync_filt: FILT_CNT must be in 0..255");
    end

    // Synchroniser chain; stage 0 is the only flop that sees data_in.
    logic [DWIDTH-1:0] sync_ff [SYNC_STAGES];
    logic [DWIDTH-1:0] sync_q;
    // Value data_out will take on the next edge; the edge pulses are
    // registered from this so they line up with the data_out change.
    logic [DWIDTH-1:0] data_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_ff[k] <= RESET_VAL;
            end
        end else begin
            sync_ff[0] <= data_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_ff[k] <= sync_ff[k-1];
            end
        end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];

    if (FILT_CNT == 0) begin : g_no_filt
        // Filter bypassed: the last sync stage is the output, and its next
        // value is simply the previous stage.
        assign data_out = sync_q;
        assign data_nxt = sync_ff[SYNC_STAGES-2];
    end else begin : g_filt
        localparam int                CNT_W   = $clog2(FILT_CNT + 1);
        localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILT_CNT - 1);

        for (genvar i = 0; i < DWIDTH; i++) begin : g_bit
            // Per-bit state only; no bit ever looks at another bit.
            logic [CNT_W-1:0] cnt;
            logic             out_q;

            // Output flips only on the FILT_CNT-th consecutive mismatch edge.
            assign data_nxt[i] = ((sync_q[i] != out_q) && (cnt == CNT_MAX)) ? sync_q[i] : out_q;
            assign data_out[i] = out_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt   <= '0;
                    out_q <= RESET_VAL[i];
                end else begin
                    out_q <= data_nxt[i];
                    // Any agreeing edge restarts the count; the count stops
                    // at CNT_MAX and clears when the output is loaded.
                    if (sync_q[i] == out_q) begin
                        cnt <= '0;
                    end else if (cnt == CNT_MAX) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

`ifdef AIB_BIT_SYNC_FILT_EDGE_EN
    logic [DWIDTH-1:0] rise_q;
    logic [DWIDTH-1:0] fall_q;

    // data_nxt and data_out are both flop-derived, so the pulses have no
    // combinational path from data_in. Reset forces data_nxt == data_out on
    // the first edge after release, so release itself cannot pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= data_nxt & ~data_out;
            fall_q <= ~data_nxt & data_out;
        end
    end

    assign rise_out = rise_q;
    assign fall_out = fall_q;
`else
    assign rise_out = '0;
    assign fall_out = '0;
`endif

endmodule

// File: tb/tb_aib_bit_sync_filt.sv
// tb/tb_aib_bit_sync_filt.sv - self-checking bench for aib_bit_sync_filt

module tb_aib_bit_sync_filt;

`ifdef AIB_BIT_SYNC_FILT_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] d;
        logic [3:0] r;
        logic [3:0] f;
    } exp_t;

    logic clk;
    logic rst;

    // u0: DWIDTH=1, SYNC_STAGES=2, FILT_CNT=4
    logic       din0, dout0, rise0, fall0;
    // u1: DWIDTH=1, SYNC_STAGES=3, FILT_CNT=0
    logic       din1, dout1, rise1, fall1;
    // u2: DWIDTH=4, SYNC_STAGES=2, FILT_CNT=4, RESET_VAL=4'b1010
    logic [3:0] din2, dout2, rise2, fall2;

    int   checks;
    int   errors;
    exp_t exp_q[$];

    aib_bit_sync_filt #(.DWIDTH(1), .SYNC_STAGES(2), .FILT_CNT(4), .RESET_VAL(1'b0)) u0 (
        .clk(clk), .rst(rst), .data_in(din0), .data_out(dout0), .rise_out(rise0), .fall_out(fall0));

    aib_bit_sync_filt #(.DWIDTH(1), .SYNC_STAGES(3), .FILT_CNT(0), .RESET_VAL(1'b0)) u1 (
        .clk(clk), .rst(rst), .data_in(din1), .data_out(dout1), .rise_out(rise1), .fall_out(fall1));

    aib_bit_sync_filt #(.DWIDTH(4), .SYNC_STAGES(2), .FILT_CNT(4), .RESET_VAL(4'b1010)) u2 (
        .clk(clk), .rst(rst), .data_in(din2), .data_out(dout2), .rise_out(rise2), .fall_out(fall2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pushes one expected single-bit output per edge for a held step input
    // that settles LAT edges after the step; pulses mark that edge.
    task automatic push_step(input int n_edges, input int lat, input logic from_v, input logic to_v);
        exp_t e;
        for (int k = 1; k <= n_edges; k++) begin
            e.d = {3'b000, (k >= lat) ? to_v : from_v};
            e.r = {3'b000, (EDGE_EN && k == lat && to_v && !from_v)};
            e.f = {3'b000, (EDGE_EN && k == lat && !to_v && from_v)};
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        din0 = 1'b0;
        din1 = 1'b0;
        din2 = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dout0 !== 1'b0) begin errors++; $display("FAIL reset_dout0: got %b expected 0", dout0); end
        checks++; if (dout1 !== 1'b0) begin errors++; $display("FAIL reset_dout1: got %b expected 0", dout1); end
        checks++; if (dout2 !== 4'b1010) begin errors++; $display("FAIL reset_dout2: got %b expected 1010", dout2); end
        checks++; if ({rise0, fall0, rise1, fall1, rise2, fall2} !== 10'b0) begin
            errors++; $display("FAIL reset_pulses: got %b expected all 0", {rise0, fall0, rise1, fall1, rise2, fall2});
        end
    endtask

    task automatic test_multibit;
        exp_t e;
        din2 = 4'b0101;
        for (int k = 1; k <= 9; k++) begin
            e.d = (k >= 6) ? 4'b0101 : 4'b1010;
            e.r = (EDGE_EN && k == 6) ? 4'b0101 : 4'b0000;
            e.f = (EDGE_EN && k == 6) ? 4'b1010 : 4'b0000;
            exp_q.push_back(e);
        end
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++; if (dout2 !== e.d) begin errors++; $display("FAIL multibit_dout edge %0d: got %b expected %b", k, dout2, e.d); end
            checks++; if (rise2 !== e.r) begin errors++; $display("FAIL multibit_rise edge %0d: got %b expected %b", k, rise2, e.r); end
            checks++; if (fall2 !== e.f) begin errors++; $display("FAIL multibit_fall edge %0d: got %b expected %b", k, fall2, e.f); end
        end
    endtask

    task automatic test_latency;
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            din0 = (pass == 0);
            push_step(10, 6, (pass != 0), (pass == 0));
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk);
                #1;
                e = exp_q.pop_front();
                checks++; if (dout0 !== e.d[0]) begin errors++; $display("FAIL latency_dout pass %0d edge %0d: got %b expected %b", pass, k, dout0, e.d[0]); end
                checks++; if (rise0 !== e.r[0]) begin errors++; $display("FAIL latency_rise pass %0d edge %0d: got %b expected %b", pass, k, rise0, e.r[0]); end
                checks++; if (fall0 !== e.f[0]) begin errors++; $display("FAIL latency_fall pass %0d edge %0d: got %b expected %b", pass, k, fall0, e.f[0]); end
            end
        end
    endtask

    task automatic test_glitch;
        exp_t e;
        // Three-cycle pulse must be swallowed entirely.
        din0 = 1'b1;
        push_step(12, 99, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++; if ({dout0, rise0, fall0} !== {e.d[0], e.r[0], e.f[0]}) begin
                errors++; $display("FAIL glitch_outputs edge %0d: got %b%b%b expected %b%b%b", k, dout0, rise0, fall0, e.d[0], e.r[0], e.f[0]);
            end
            if (k == 3) din0 = 1'b0;
        end
        // Counter must restart from zero: a held step still takes the full latency.
        din0 = 1'b1;
        push_step(8, 6, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++; if (dout0 !== e.d[0]) begin errors++; $display("FAIL glitch_restart_dout edge %0d: got %b expected %b", k, dout0, e.d[0]); end
            checks++; if (rise0 !== e.r[0]) begin errors++; $display("FAIL glitch_restart_rise edge %0d: got %b expected %b", k, rise0, e.r[0]); end
        end
        din0 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_bypass;
        exp_t e;
        int   fall_seen;
        fall_seen = 0;
        for (int k = 1; k <= 14; k++) begin
            e.d = {3'b000, (k >= 3 && k <= 7)};
            e.r = {3'b000, (EDGE_EN && k == 3)};
            e.f = {3'b000, (EDGE_EN && k == 8)};
            exp_q.push_back(e);
        end
        din1 = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            if (fall1 === 1'b1) fall_seen++;
            checks++; if (dout1 !== e.d[0]) begin errors++; $display("FAIL bypass_dout edge %0d: got %b expected %b", k, dout1, e.d[0]); end
            checks++; if (rise1 !== e.r[0]) begin errors++; $display("FAIL bypass_rise edge %0d: got %b expected %b", k, rise1, e.r[0]); end
            checks++; if (fall1 !== e.f[0]) begin errors++; $display("FAIL bypass_fall edge %0d: got %b expected %b", k, fall1, e.f[0]); end
            if (k == 5) din1 = 1'b0;
        end
        checks++; if (fall_seen !== (EDGE_EN ? 1 : 0)) begin
            errors++; $display("FAIL bypass_fall_count: got %0d expected %0d", fall_seen, (EDGE_EN ? 1 : 0));
        end
    endtask

    task automatic test_reset_mid_count;
        exp_t e;
        din0 = 1'b1;
        // Edges 3 and 4 advance the counter to 2 of 4.
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (dout0 !== 1'b0) begin errors++; $display("FAIL midcount_in_reset: got %b expected 0", dout0); end
        @(posedge clk);
        #1;
        push_step(8, 6, 1'b0, 1'b1);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++; if (dout0 !== e.d[0]) begin errors++; $display("FAIL midcount_dout edge %0d: got %b expected %b", k, dout0, e.d[0]); end
            checks++; if (rise0 !== e.r[0]) begin errors++; $display("FAIL midcount_rise edge %0d: got %b expected %b", k, rise0, e.r[0]); end
        end
        // Asynchronous assertion: outputs return to reset value without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        checks++; if (dout0 !== 1'b0) begin errors++; $display("FAIL async_reset_dout0: got %b expected 0", dout0); end
        checks++; if (dout2 !== 4'b1010) begin errors++; $display("FAIL async_reset_dout2: got %b expected 1010", dout2); end
        checks++; if ({rise0, fall0, rise2, fall2} !== 10'b0) begin
            errors++; $display("FAIL async_reset_pulses: got %b expected all 0", {rise0, fall0, rise2, fall2});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_multibit();
        test_latency();
        test_glitch();
        test_bypass();
        test_reset_mid_count();
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
